// File: rtl/ppc_types.sv
// Shared PowerPC integer-unit types: exception flags, CR0 field and buffered result entry.
package ppc_types;

    localparam int unsigned RsIdWidth = 5;

    typedef struct packed {
        logic ca;
        logic ov;
        logic ov_valid;
        logic cr0_valid;
    } cond_exception_t;

    typedef struct packed {
        logic lt;
        logic gt;
        logic eq;
        logic so;
    } cr0_t;

    // rs_id is sized by the package default; instances must keep RS_ID_WIDTH equal to it.
    typedef struct packed {
        logic [RsIdWidth-1:0] rs_id;
        logic [4:0]           reg_addr;
        logic [0:31]          result;
        cr0_t                 cr0;
        cond_exception_t      flags;
    } result_entry_t;

endpackage

// File: rtl/exec_result_buffer_if.sv
// Result-to-CDB handshake bundle: the buffer presents the head entry, the arbiter grants it.
interface exec_result_buffer_if
    import ppc_types::*;
#(
    parameter int unsigned RS_ID_WIDTH = RsIdWidth
) ();

    logic                   cdb_valid;
    logic                   cdb_ready;
    logic [RS_ID_WIDTH-1:0] cdb_rs_id;
    logic [4:0]             cdb_reg_addr;
    logic [0:31]            cdb_result;
    logic [3:0]             cdb_cr0;
    cond_exception_t        cdb_flags;

    modport master (
        output cdb_valid, cdb_rs_id, cdb_reg_addr, cdb_result, cdb_cr0, cdb_flags,
        input  cdb_ready
    );

    modport slave (
        input  cdb_valid, cdb_rs_id, cdb_reg_addr, cdb_result, cdb_cr0, cdb_flags,
        output cdb_ready
    );

endinterface

// File: rtl/cr0_compute.sv
// CR0 {LT,GT,EQ,SO} from a 32-bit result (bit 0 = MSB), its overflow flags and XER[SO].
module cr0_compute
    import ppc_types::*;
(
    input  logic [0:31] result,
    input  logic        ov_valid,
    input  logic        ov,
    input  logic        xer_so,
    output cr0_t        cr0
);

    logic is_zero;

    assign is_zero = (result == '0);

    always_comb begin
        cr0.lt = result[0];
        cr0.gt = ~result[0] & ~is_zero;
        cr0.eq = is_zero;
        cr0.so = xer_so | (ov_valid & ov);
    end

endmodule

// File: rtl/exec_result_buffer.sv
// Credit-gated result FIFO between a fixed-latency execution unit and the CDB arbiter.
module exec_result_buffer
    import ppc_types::*;
#(
    parameter int unsigned RS_ID_WIDTH = RsIdWidth,
    parameter int unsigned DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_fire,
    output logic                   issue_allow,
    input  logic                   flush,
    input  logic                   xer_so,
    input  logic                   in_valid,
    input  logic [RS_ID_WIDTH-1:0] in_rs_id,
    input  logic [4:0]             in_reg_addr,
    input  logic [0:31]            in_result,
    input  cond_exception_t        in_cr0_xer,
    exec_result_buffer_if.master   cdb,
    output logic                   overflow_err
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] Full = CntW'(DEPTH);

    result_entry_t   mem_q [DEPTH];
    result_entry_t   new_entry;
    result_entry_t   head;
    cr0_t            in_cr0;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d, in_flight_q, in_flight_d, discard_q, discard_d;
    logic            overflow_q, overflow_d;
    logic            discard_arrival, deq, enq, drop, dec_flight;

    cr0_compute u_cr0 (
        .result   (in_result),
        .ov_valid (in_cr0_xer.ov_valid),
        .ov       (in_cr0_xer.ov),
        .xer_so   (xer_so),
        .cr0      (in_cr0)
    );

    assign new_entry = '{rs_id:    RsIdWidth'(in_rs_id),
                         reg_addr: in_reg_addr,
                         result:   in_result,
                         cr0:      in_cr0,
                         flags:    in_cr0_xer};

    assign head             = mem_q[rd_ptr_q];
    assign cdb.cdb_valid    = (count_q != '0);
    assign cdb.cdb_rs_id    = RS_ID_WIDTH'(head.rs_id);
    assign cdb.cdb_reg_addr = head.reg_addr;
    assign cdb.cdb_result   = head.result;
    assign cdb.cdb_cr0      = head.cr0;
    assign cdb.cdb_flags    = head.flags;
    assign overflow_err     = overflow_q;

    // Reserving a slot per in-flight op guarantees every arrival finds room.
    assign issue_allow = ({1'b0, count_q} + {1'b0, in_flight_q}) < {1'b0, Full};

    always_comb begin
        discard_arrival = in_valid & (flush | (discard_q != '0));
        deq             = cdb.cdb_valid & cdb.cdb_ready & ~flush;
        enq             = in_valid & ~discard_arrival & ((count_q != Full) | deq);
        drop            = in_valid & ~discard_arrival & (count_q == Full) & ~deq;
        dec_flight      = in_valid & (in_flight_q != '0);

        in_flight_d = in_flight_q + CntW'(issue_fire) - CntW'(dec_flight);
        wr_ptr_d    = wr_ptr_q + PtrW'(enq);
        rd_ptr_d    = rd_ptr_q + PtrW'(deq);
        count_d     = count_q + CntW'(enq) - CntW'(deq);
        discard_d   = discard_q - CntW'(in_valid & (discard_q != '0));
        overflow_d  = overflow_q | drop;

        // Everything still in flight after this cycle (including a same-cycle issue) is discarded.
        if (flush) begin
            count_d   = '0;
            rd_ptr_d  = wr_ptr_q;
            discard_d = in_flight_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_flight_q <= '0;
            discard_q   <= '0;
            overflow_q  <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_flight_q <= in_flight_d;
            discard_q   <= discard_d;
            overflow_q  <= overflow_d;
            if (enq) begin
                mem_q[wr_ptr_q] <= new_entry;
            end
        end
    end

endmodule

// File: tb/tb_exec_result_buffer.sv
// Scoreboard bench for exec_result_buffer: directed scenarios followed by random traffic.
module tb_exec_result_buffer;
    import ppc_types::*;

    localparam int DEPTH = 4;
    localparam int RSW   = 5;

    logic            clk = 1'b0;
    logic            rst, issue_fire, issue_allow, flush, xer_so, in_valid, overflow_err;
    logic [RSW-1:0]  in_rs_id;
    logic [4:0]      in_reg_addr;
    logic [0:31]     in_result;
    cond_exception_t in_cr0_xer;

    exec_result_buffer_if #(.RS_ID_WIDTH(RSW)) cdb_if ();

    exec_result_buffer #(.RS_ID_WIDTH(RSW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_fire   (issue_fire),
        .issue_allow  (issue_allow),
        .flush        (flush),
        .xer_so       (xer_so),
        .in_valid     (in_valid),
        .in_rs_id     (in_rs_id),
        .in_reg_addr  (in_reg_addr),
        .in_result    (in_result),
        .in_cr0_xer   (in_cr0_xer),
        .cdb          (cdb_if),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs_id;
        logic [4:0]  reg_addr;
        logic [31:0] result;
        logic [3:0]  cr0;
        logic [3:0]  flags;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0, miscompares = 0;
    int   m_cnt = 0, m_flight = 0, m_discard = 0;
    bit   m_ovf = 1'b0, started = 1'b0;
    int   banned = -1;

    function automatic logic [3:0] ref_cr0(input logic [31:0] r, input logic so,
                                           input cond_exception_t f);
        int s;
        logic [3:0] c;
        s    = r;
        c[3] = (s < 0);
        c[2] = (s > 0);
        c[1] = (s == 0);
        c[0] = so | (f.ov_valid & f.ov);
        return c;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: occupancy, credits and pending discards, updated on each sampled edge.
    initial forever begin
        int nf;
        bit disc, deq;
        exp_t e;
        @(posedge clk);
        if (rst) begin
            m_cnt = 0; m_flight = 0; m_discard = 0; m_ovf = 1'b0;
            exp_q.delete();
        end else begin
            if (started && issue_fire)
                check("issue_protocol", (m_cnt + m_flight) < DEPTH, 1);
            nf   = m_flight + int'(issue_fire) - ((in_valid && m_flight > 0) ? 1 : 0);
            disc = in_valid && (flush || m_discard > 0);
            deq  = (m_cnt > 0) && cdb_if.cdb_ready && !flush;
            if (flush) begin
                m_cnt = 0;
                exp_q.delete();
                m_discard = nf;
            end else begin
                if (in_valid && m_discard > 0) m_discard--;
                if (in_valid && !disc) begin
                    if (m_cnt < DEPTH || deq) begin
                        e.rs_id    = in_rs_id;
                        e.reg_addr = in_reg_addr;
                        e.result   = in_result;
                        e.cr0      = ref_cr0(in_result, xer_so, in_cr0_xer);
                        e.flags    = in_cr0_xer;
                        exp_q.push_back(e);
                        m_cnt++;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
                if (deq) m_cnt--;
            end
            m_flight = nf;
        end
    end

    // Monitor: checks status every cycle and pops the scoreboard on each CDB handshake.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (started) begin
            check("cdb_valid", cdb_if.cdb_valid, m_cnt != 0);
            check("issue_allow", issue_allow, (m_cnt + m_flight) < DEPTH);
            check("overflow_err", overflow_err, m_ovf);
            if (cdb_if.cdb_valid && banned >= 0)
                check("dropped_tag_absent", int'(cdb_if.cdb_rs_id) == banned, 0);
            if (cdb_if.cdb_valid && cdb_if.cdb_ready && !flush && !rst) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output_rs_id", cdb_if.cdb_rs_id, 64'hffff);
                end else begin
                    e = exp_q.pop_front();
                    check("cdb_rs_id", cdb_if.cdb_rs_id, e.rs_id);
                    check("cdb_reg_addr", cdb_if.cdb_reg_addr, e.reg_addr);
                    check("cdb_result", cdb_if.cdb_result, e.result);
                    check("cdb_cr0", cdb_if.cdb_cr0, e.cr0);
                    check("cdb_flags", cdb_if.cdb_flags, e.flags);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue();
        issue_fire = 1'b1;
        tick();
        issue_fire = 1'b0;
    endtask

    task automatic arrive(input logic [4:0] tag, input logic [31:0] r, input logic so,
                          input cond_exception_t f);
        in_valid    = 1'b1;
        in_rs_id    = tag;
        in_reg_addr = 5'($urandom);
        in_result   = r;
        xer_so      = so;
        in_cr0_xer  = f;
        tick();
        in_valid    = 1'b0;
        in_result   = $urandom;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cdb_valid"}, cdb_if.cdb_valid, 0);
        check({tag, "_cdb_rs_id"}, cdb_if.cdb_rs_id, 0);
        check({tag, "_cdb_reg_addr"}, cdb_if.cdb_reg_addr, 0);
        check({tag, "_cdb_result"}, cdb_if.cdb_result, 0);
        check({tag, "_cdb_cr0"}, cdb_if.cdb_cr0, 0);
        check({tag, "_cdb_flags"}, cdb_if.cdb_flags, 0);
        check({tag, "_overflow_err"}, overflow_err, 0);
        check({tag, "_issue_allow"}, issue_allow, 1);
    endtask

    initial begin
        cond_exception_t f_none, f_ov;
        f_none = '0;
        f_ov   = '0;
        f_ov.ov_valid = 1'b1;
        f_ov.ov       = 1'b1;

        rst = 1'b1; issue_fire = 1'b0; flush = 1'b0; xer_so = 1'b0; in_valid = 1'b0;
        in_rs_id = '0; in_reg_addr = '0; in_result = '0; in_cr0_xer = '0;
        cdb_if.cdb_ready = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        started = 1'b1;

        // Credits run out after DEPTH issues; a zero result yields CR0 = EQ.
        cdb_if.cdb_ready = 1'b1;
        repeat (DEPTH) issue();
        check("allow_after_4_issues", issue_allow, 0);
        arrive(5'd3, 32'h0, 1'b0, f_none);
        check("t1_valid", cdb_if.cdb_valid, 1);
        check("t1_cr0", cdb_if.cdb_cr0, 4'b0010);
        check("t1_rs_id", cdb_if.cdb_rs_id, 3);
        tick();
        check("t1_allow_back", issue_allow, 1);

        arrive(5'd4, 32'h8000_0000, 1'b0, f_none);
        check("t2_cr0_neg", cdb_if.cdb_cr0, 4'b1000);
        arrive(5'd5, 32'h0000_0005, 1'b1, f_none);
        check("t2_cr0_pos_so", cdb_if.cdb_cr0, 4'b0101);
        arrive(5'd6, 32'h0, 1'b0, f_ov);
        check("t2_cr0_zero_ov", cdb_if.cdb_cr0, 4'b0011);
        tick();

        // Full FIFO with a simultaneous dequeue and arrival must not overflow.
        cdb_if.cdb_ready = 1'b0;
        repeat (DEPTH) issue();
        for (int i = 0; i < DEPTH; i++) arrive(5'(8 + i), $urandom, 1'($urandom), f_none);
        check("t3_full_allow", issue_allow, 0);
        cdb_if.cdb_ready = 1'b1;
        arrive(5'd12, $urandom, 1'b0, f_none);
        check("t3_no_overflow", overflow_err, 0);
        check("t3_still_valid", cdb_if.cdb_valid, 1);
        repeat (DEPTH + 1) tick();
        check("t3_drained", cdb_if.cdb_valid, 0);

        // Arrival while full with no dequeue is dropped and latches overflow_err.
        cdb_if.cdb_ready = 1'b0;
        repeat (DEPTH) issue();
        for (int i = 0; i < DEPTH; i++) arrive(5'(16 + i), $urandom, 1'b0, f_none);
        arrive(5'd20, $urandom, 1'b0, f_none);
        check("t4_overflow_set", overflow_err, 1);
        banned = 20;
        cdb_if.cdb_ready = 1'b1;
        repeat (DEPTH + 2) tick();
        check("t4_overflow_sticky", overflow_err, 1);

        // Flush with two stored and two in flight; op issued afterwards survives.
        cdb_if.cdb_ready = 1'b0;
        repeat (DEPTH) issue();
        arrive(5'd21, $urandom, 1'b0, f_none);
        arrive(5'd22, $urandom, 1'b0, f_none);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_flushed", cdb_if.cdb_valid, 0);
        issue();
        arrive(5'd23, $urandom, 1'b0, f_none);
        arrive(5'd24, $urandom, 1'b0, f_none);
        check("t5_discarded", cdb_if.cdb_valid, 0);
        cdb_if.cdb_ready = 1'b1;
        arrive(5'd7, 32'h1234, 1'b0, f_none);
        check("t5_tag7_valid", cdb_if.cdb_valid, 1);
        check("t5_tag7_rs_id", cdb_if.cdb_rs_id, 7);
        tick();

        // Reset mid-operation clears state; a late arrival is stored normally.
        cdb_if.cdb_ready = 1'b0;
        repeat (DEPTH) issue();
        for (int i = 0; i < 3; i++) arrive(5'(25 + i), $urandom, 1'b0, f_none);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("midrst");
        banned = -1;
        arrive(5'd9, 32'hffff_fff0, 1'b0, f_none);
        check("t6_late_valid", cdb_if.cdb_valid, 1);
        check("t6_late_rs_id", cdb_if.cdb_rs_id, 9);
        check("t6_late_cr0", cdb_if.cdb_cr0, 4'b1000);
        cdb_if.cdb_ready = 1'b1;
        tick();

        // Random traffic: issues within credit, arrivals per in-flight op, occasional flush.
        for (int c = 0; c < 1500; c++) begin
            logic [31:0] r;
            cdb_if.cdb_ready = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 29) == 0);
            issue_fire = issue_allow && ($urandom_range(0, 1) == 1);
            in_valid   = (m_flight > 0) && ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0:       r = 32'h0;
                1:       r = 32'h8000_0000 | $urandom;
                default: r = $urandom;
            endcase
            in_rs_id    = 5'($urandom);
            in_reg_addr = 5'($urandom);
            in_result   = r;
            xer_so      = 1'($urandom);
            in_cr0_xer  = cond_exception_t'($urandom);
            tick();
        end
        issue_fire = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        cdb_if.cdb_ready = 1'b1;
        for (int k = 0; k < 4 * DEPTH && m_flight > 0; k++)
            arrive(5'($urandom), $urandom, 1'($urandom), f_none);
        repeat (DEPTH + 2) tick();
        check("final_empty", cdb_if.cdb_valid, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/exec_result_buffer.md
Name: exec_result_buffer

Overview:
- Receiving end of the execution-unit result interface (output_valid/rs_id_out/result_reg_addr_out/result/cr0_xer) for fixed-latency units such as the rotate unit.
- Those units ignore output_ready. This block grants issue credits upstream, buffers results in a FIFO, computes the CR0 field, and presents entries to the common data bus (CDB) with a valid/ready handshake.
- One instance sits between each execution unit and the CDB arbiter.

Parameters:
- RS_ID_WIDTH, 5, width of the reservation-station tag.
- DEPTH, 4, number of FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- issue_fire  in  1  unit accepted an operation this cycle (unit input_valid & input_ready)
- issue_allow  out  1  an operation may be issued to the unit
- flush  in  1  discard all buffered and in-flight results
- xer_so  in  1  current XER[SO]
- in_valid  in  1  unit result valid
- in_rs_id  in  RS_ID_WIDTH  unit result tag
- in_reg_addr  in  5  destination GPR
- in_result  in  32  result, bit 0 = MSB
- in_cr0_xer  in  cond_exception_t  CA/OV/CR0_valid flags
- cdb_valid  out  1  head entry valid
- cdb_ready  in  1  arbiter grants the CDB
- cdb_rs_id  out  RS_ID_WIDTH  head tag
- cdb_reg_addr  out  5  head destination
- cdb_result  out  32  head result
- cdb_cr0  out  4  {LT,GT,EQ,SO}
- cdb_flags  out  cond_exception_t  head flags, passed through
- overflow_err  out  1  sticky: result arrived while the FIFO was full

Behaviour:
- Decided: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: all outputs are 0 (cdb_valid=0, cdb_* =0, overflow_err=0), except issue_allow=1. Pointers, count, in_flight and discard_cnt are all 0.

Counters:
- count: number of stored entries, 0..DEPTH.
- in_flight: issued but not yet arrived, 0..DEPTH.
- issue_allow = (count + in_flight) < DEPTH, purely combinational from registers. This guarantees a free slot for every arrival.
- in_flight: +1 on issue_fire, -1 on in_valid. If both occur in the same cycle it is unchanged.
- issue_fire while issue_allow=0 is a protocol error. The bench asserts on it; the RTL does not recover.

Enqueue (in_valid=1, not being discarded):
- Write the entry at wr_ptr.
- CR0 is computed at enqueue and stored:
  - LT = in_result[0]
  - GT = ~in_result[0] & (in_result != 0)
  - EQ = (in_result == 0)
  - SO = xer_so | (in_cr0_xer.OV_valid & in_cr0_xer.OV)
- The CR0 bits are stored regardless of CR0_valid; the consumer gates on cdb_flags.CR0_valid.
- If count==DEPTH with no simultaneous dequeue, drop the entry and set overflow_err. It clears only on rst.

Dequeue:
- Occurs when cdb_valid & cdb_ready.
- cdb_* are driven from registered FIFO storage at rd_ptr. An entry enqueued at cycle N is visible at N+1.
- Enqueue and dequeue in the same cycle is legal at any count, including full; count is unchanged.
- Pointers wrap modulo DEPTH.

Flush:
- Takes effect the next cycle: count=0 and pointers equal, so cdb_valid=0.
- discard_cnt <= in_flight adjusted for that cycle's issue_fire/in_valid.
- in_flight is kept: it still decrements as the discarded results arrive.
- While discard_cnt>0, each in_valid decrements discard_cnt and is not stored.
- issue_fire in the flush cycle itself counts as a discarded operation.
- flush together with cdb_ready: the dequeue is not performed; the entry is dropped.
- rst mid-operation: everything clears and no discards are pending.

cdb_valid=0 ⇒ cdb_cr0, cdb_rs_id and the other payload outputs are don't-care; the bench must not check them.

Decomposition:
- ppc_types package:
  - existing cond_exception_t
  - new cr0_t packed struct {LT,GT,EQ,SO}
  - new result_entry_t {rs_id, reg_addr, result, cr0, flags}
- RS_ID_WIDTH stays a parameter, so the rs_id field is sized in the module, or the package uses a default constant.
- Sub-module cr0_compute (combinational: result, OV flags, xer_so → cr0_t). It is reused by the other integer units.

Test Plan:
- Issue 4 ops, no results: issue_allow drops to 0 after the 4th issue_fire. Deliver result 0x00000000 tag 3, cdb_ready=1: cdb_valid next cycle, cdb_cr0=0010, cdb_rs_id=3; issue_allow back to 1 one cycle after the arrival.
- Results 0x80000000 (xer_so=0), 0x00000005 (xer_so=1), 0x00000000 with OV_valid=1, OV=1 → cdb_cr0 = 1000, 0101, 0011, in order.
- cdb_ready=0, fill all 4 entries, then cdb_ready=1 with a simultaneous 5th arrival (DEPTH=4): no overflow_err; order preserved; count stays 4 that cycle.
- Force a 5th arrival while full with cdb_ready=0 (bypassing issue_allow): overflow_err=1 stays set; the dropped tag never appears on cdb_rs_id.
- 2 entries stored, 2 in flight, flush: cdb_valid=0 next cycle; the next 2 arrivals are discarded. The 3rd (tag 7, issued after the flush) appears on the CDB.
- rst asserted while 3 entries are stored and 1 is in flight: all outputs return to their reset values next cycle. The late arrival after reset is stored normally (no discard).
